ad9228_lvds_emulator_tx: RTL and testbench
==========================================

Name: ad9228_lvds_emulator_tx

Overview:
- Transmit-side counterpart of the AD9228 serial capture path: serializes parallel per-channel samples into AD9228-style framed bitstreams (data lanes, FCO frame clock, DCO bit clock).
- Used for loopback and bench stimulus of the ADC capture chain and as a board-level ADC stand-in.
- One bit per clk cycle (SDR); output buffers and diff conversion sit outside this block.

Parameters:
- NUM_CHANNELS, 4, number of serial data lanes.
- DATA_WIDTH, 12, bits per sample per frame; even, >=4.
- IDLE_WORD, 12'h800, word sent on every lane when a frame starts with no sample available (underrun).
- CNT_WIDTH, 16, width of the underrun counter.

Ports:
- clk  in  1  bit-rate clock; one serial bit per cycle.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  run request; sampled each cycle.
- test_mode  in  1  1 = ramp pattern replaces s_data; sampled at frame boundary only.
- s_data  in  NUM_CHANNELS*DATA_WIDTH  sample set; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_valid  in  1  s_data valid.
- s_ready  out  1  block accepts s_data this cycle.
- dout  out  NUM_CHANNELS  serial data lanes, MSB first.
- fco  out  1  frame clock.
- dco  out  1  bit clock.
- frame_start  out  1  one-cycle pulse coincident with bit 0 of each frame on dout.
- busy  out  1  high while a frame is being shifted.
- underrun_cnt  out  CNT_WIDTH  saturating count of underrun frames.

Behaviour:
- Reset values: dout=0, fco=0, dco=0, s_ready=0, frame_start=0, busy=0, underrun_cnt=0, ramp=0, state=IDLE. All outputs are registered.
- FSM state IDLE:
  - outputs held 0, except s_ready = enable.
  - Exit: enable=1 -> LOAD at next edge.
- FSM state LOAD (boundary cycle; also the last bit cycle of each RUN frame):
  - If test_mode=1: the frame word is ramp on every lane; s_ready=0; ramp increments (mod 2^DATA_WIDTH) per frame.
  - Else if s_valid && s_ready: word = s_data.
  - Else: word = IDLE_WORD on every lane; underrun_cnt += 1 (saturates at all-ones).
- FSM state RUN:
  - bit_cnt counts 0..DATA_WIDTH-1.
  - dout[i] = word_i[DATA_WIDTH-1-bit_cnt].
  - fco = 1 for bit_cnt < DATA_WIDTH/2, else 0.
  - dco = 1 on even bit_cnt, 0 on odd (toggles every cycle).
  - frame_start = (bit_cnt==0); busy = 1.
- Boundary handshake in RUN:
  - At bit_cnt==DATA_WIDTH-1, s_ready = enable && !test_mode; acceptance/underrun resolution as in LOAD.
  - If enable=1, the next frame begins with no gap.
  - If enable=0, the FSM returns to IDLE after that last bit; frames are never truncated by enable.
- Latency: s_data accepted at edge t -> its MSB is on dout and frame_start=1 during cycle t+1. enable rise at edge t -> first frame_start at t+2.
- Boundary conditions:
  - s_valid outside s_ready cycles: ignored; data must be held by the source (AXI-style).
  - enable drop mid-frame: the current frame completes.
  - test_mode toggle mid-frame: takes effect at the next boundary.
  - rstn asserted mid-frame: immediate return to reset values; the partial frame is abandoned.
  - ramp wraps from 2^DATA_WIDTH-1 to 0.

Test Plan:
- Reset, enable=1, s_valid=1, lane0 s_data=12'hA5C -> lane0 dout 1,0,1,0,0,1,0,1,1,1,0,0; fco 1 x6 then 0 x6; dco 1,0,1,0...; frame_start on first bit at t+1.
- Back-to-back samples 12'h001 then 12'hFFF, s_valid held -> two contiguous frames with no gap; s_ready high only on boundary cycles; underrun_cnt=0.
- s_valid=0 at a boundary -> that frame is 12'h800 on all lanes; underrun_cnt=1; with CNT_WIDTH=2, five underruns -> underrun_cnt saturates at 3.
- test_mode=1 for 4097 frames -> lane words 0,1,...,4095,0; s_ready stays 0.
- enable dropped at bit 3 -> frame completes all 12 bits, then busy=0 and dout/fco/dco=0; rstn pulsed at bit 5 of a later frame -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/ad9228_lvds_emulator_tx.sv
// AD9228-style serializer: parallel per-channel samples go out MSB first on the data lanes,
// framed by FCO and clocked by DCO, with one bit per clk cycle.
module ad9228_lvds_emulator_tx #(
   parameter int                    NUM_CHANNELS = 4,
   parameter int                    DATA_WIDTH   = 12,
   parameter logic [DATA_WIDTH-1:0] IDLE_WORD    = 12'h800,
   parameter int                    CNT_WIDTH    = 16
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic                                 enable,
   input  logic                                 test_mode,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   s_data,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   output logic [NUM_CHANNELS-1:0]              dout,
   output logic                                 fco,
   output logic                                 dco,
   output logic                                 frame_start,
   output logic                                 busy,
   output logic [CNT_WIDTH-1:0]                 underrun_cnt
);

   localparam int                    CW       = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0]         LAST_BIT = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0]         PRE_LAST = CW'(DATA_WIDTH - 2);
   localparam logic [CW-1:0]         HALF     = CW'(DATA_WIDTH / 2);
   localparam logic [CW-1:0]         BIT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] RAMP_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (&v) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_ONE;
      end
   endfunction

   state_t                                       state_q, state_d;
   logic [CW-1:0]                                bit_cnt_q, bit_cnt_d;
   logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]      shift_q, shift_d;
   logic [DATA_WIDTH-1:0]                        ramp_q, ramp_d;
   logic [CNT_WIDTH-1:0]                         underrun_q, underrun_d;
   logic [NUM_CHANNELS-1:0]                      dout_q, dout_d;
   logic                                         fco_q, fco_d;
   logic                                         dco_q, dco_d;
   logic                                         fs_q, fs_d;
   logic                                         busy_q, busy_d;
   logic                                         s_ready_q, s_ready_d;
   // go/tm hold the enable and test_mode values captured together with s_ready,
   // so the boundary decision always agrees with the handshake the source saw.
   logic                                         go_q, go_d;
   logic                                         tm_q, tm_d;

   logic                                         last_bit_s;
   logic                                         start_s;
   logic                                         accept_s;
   logic                                         underrun_s;
   logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]      frame_word_s;

   // Frame-boundary decode and per-lane selection of the next frame word.
   always_comb begin
      last_bit_s = (state_q == S_RUN) && (bit_cnt_q == LAST_BIT);
      start_s    = (state_q == S_LOAD) || (last_bit_s && go_q);
      accept_s   = s_valid && s_ready_q;
      underrun_s = !tm_q && !accept_s;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (tm_q) begin
            frame_word_s[i] = ramp_q;
         end else if (accept_s) begin
            frame_word_s[i] = s_data[i*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            frame_word_s[i] = IDLE_WORD;
         end
      end
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      ramp_d     = ramp_q;
      underrun_d = underrun_q;
      dout_d     = dout_q;
      fco_d      = fco_q;
      dco_d      = dco_q;
      fs_d       = 1'b0;
      busy_d     = busy_q;
      s_ready_d  = 1'b0;
      go_d       = go_q;
      tm_d       = tm_q;

      case (state_q)
         S_IDLE: begin
            bit_cnt_d = '0;
            dout_d    = '0;
            fco_d     = 1'b0;
            dco_d     = 1'b0;
            busy_d    = 1'b0;
            if (enable) begin
               state_d   = S_LOAD;
               s_ready_d = !test_mode;
               go_d      = 1'b1;
               tm_d      = test_mode;
            end else begin
               state_d   = S_IDLE;
            end
         end

         S_LOAD, S_RUN: begin
            if (start_s) begin
               // The output flops take the MSB directly so bit 0 follows acceptance by one cycle.
               state_d   = S_RUN;
               bit_cnt_d = '0;
               for (int i = 0; i < NUM_CHANNELS; i++) begin
                  dout_d[i]  = frame_word_s[i][DATA_WIDTH-1];
                  shift_d[i] = {frame_word_s[i][DATA_WIDTH-2:0], 1'b0};
               end
               fco_d  = 1'b1;
               dco_d  = 1'b1;
               fs_d   = 1'b1;
               busy_d = 1'b1;
               if (tm_q) begin
                  ramp_d = ramp_q + RAMP_ONE;
               end else begin
                  ramp_d = ramp_q;
               end
               if (underrun_s) begin
                  underrun_d = sat_inc(underrun_q);
               end else begin
                  underrun_d = underrun_q;
               end
            end else if (last_bit_s) begin
               state_d   = S_IDLE;
               bit_cnt_d = '0;
               dout_d    = '0;
               fco_d     = 1'b0;
               dco_d     = 1'b0;
               busy_d    = 1'b0;
            end else begin
               state_d   = S_RUN;
               bit_cnt_d = bit_cnt_q + BIT_ONE;
               for (int i = 0; i < NUM_CHANNELS; i++) begin
                  dout_d[i]  = shift_q[i][DATA_WIDTH-1];
                  shift_d[i] = {shift_q[i][DATA_WIDTH-2:0], 1'b0};
               end
               fco_d  = (bit_cnt_d < HALF);
               dco_d  = ~bit_cnt_d[0];
               busy_d = 1'b1;
               if (bit_cnt_q == PRE_LAST) begin
                  s_ready_d = enable && !test_mode;
                  go_d      = enable;
                  tm_d      = test_mode;
               end else begin
                  s_ready_d = 1'b0;
               end
            end
         end

         default: begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            dout_d    = '0;
            fco_d     = 1'b0;
            dco_d     = 1'b0;
            busy_d    = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         ramp_q     <= '0;
         underrun_q <= '0;
         dout_q     <= '0;
         fco_q      <= 1'b0;
         dco_q      <= 1'b0;
         fs_q       <= 1'b0;
         busy_q     <= 1'b0;
         s_ready_q  <= 1'b0;
         go_q       <= 1'b0;
         tm_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         ramp_q     <= ramp_d;
         underrun_q <= underrun_d;
         dout_q     <= dout_d;
         fco_q      <= fco_d;
         dco_q      <= dco_d;
         fs_q       <= fs_d;
         busy_q     <= busy_d;
         s_ready_q  <= s_ready_d;
         go_q       <= go_d;
         tm_q       <= tm_d;
      end
   end

   assign s_ready      = s_ready_q;
   assign dout         = dout_q;
   assign fco          = fco_q;
   assign dco          = dco_q;
   assign frame_start  = fs_q;
   assign busy         = busy_q;
   assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_ad9228_lvds_emulator_tx.sv
// Directed bench for ad9228_lvds_emulator_tx; a second instance with a 2-bit underrun
// counter shares the stimulus to exercise saturation.
module tb_ad9228_lvds_emulator_tx;

   logic          clk = 1'b0;
   logic          rstn;
   logic          enable;
   logic          test_mode;
   logic [47:0]   s_data;
   logic          s_valid;
   logic          s_ready;
   logic [3:0]    dout;
   logic          fco, dco, frame_start, busy;
   logic [15:0]   underrun_cnt;
   logic          s_ready2;
   logic [3:0]    dout2;
   logic          fco2, dco2, frame_start2, busy2;
   logic [1:0]    underrun_cnt2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ad9228_lvds_emulator_tx #(
      .NUM_CHANNELS(4), .DATA_WIDTH(12), .IDLE_WORD(12'h800), .CNT_WIDTH(16)
   ) dut (
      .clk(clk), .rstn(rstn), .enable(enable), .test_mode(test_mode),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .dout(dout),
      .fco(fco), .dco(dco), .frame_start(frame_start), .busy(busy),
      .underrun_cnt(underrun_cnt)
   );

   ad9228_lvds_emulator_tx #(
      .NUM_CHANNELS(4), .DATA_WIDTH(12), .IDLE_WORD(12'h800), .CNT_WIDTH(2)
   ) dut2 (
      .clk(clk), .rstn(rstn), .enable(enable), .test_mode(test_mode),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2), .dout(dout2),
      .fco(fco2), .dco(dco2), .frame_start(frame_start2), .busy(busy2),
      .underrun_cnt(underrun_cnt2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at the negedge showing bit 0; returns at the negedge showing bit 11.
   task automatic frame(input string tag, input logic [47:0] exp_word, input logic exp_last_ready,
                        input int drop_at, input int rst_at);
      logic [3:0][11:0] lw;
      logic [11:0] fco_p, dco_p, fs_p, busy_p, rdy_p;
      lw = '0; fco_p = '0; dco_p = '0; fs_p = '0; busy_p = '0; rdy_p = '0;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         for (int i = 0; i < 4; i++) lw[i] = {lw[i][10:0], dout[i]};
         fco_p  = {fco_p[10:0], fco};
         dco_p  = {dco_p[10:0], dco};
         fs_p   = {fs_p[10:0], frame_start};
         busy_p = {busy_p[10:0], busy};
         rdy_p  = {rdy_p[10:0], s_ready};
         if (k == drop_at) enable = 1'b0;
         if (k == rst_at) begin
            rstn = 1'b0;
            #1;
            chk($sformatf("%s outs_after_rst", tag), {dout, fco, dco, frame_start, busy, s_ready}, 64'h0);
            chk($sformatf("%s cnt_after_rst", tag), {underrun_cnt, 2'b00, underrun_cnt2}, 64'h0);
            return;
         end
      end
      chk($sformatf("%s word", tag), lw, exp_word);
      chk($sformatf("%s fco", tag), fco_p, 12'hFC0);
      chk($sformatf("%s dco", tag), dco_p, 12'hAAA);
      chk($sformatf("%s frame_start", tag), fs_p, 12'h800);
      chk($sformatf("%s busy", tag), busy_p, 12'hFFF);
      chk($sformatf("%s s_ready", tag), rdy_p, {11'b0, exp_last_ready});
   endtask

   initial begin
      logic [11:0] rj;
      rstn = 1'b0; enable = 1'b0; test_mode = 1'b0; s_valid = 1'b0; s_data = 48'h0;
      repeat (2) @(negedge clk);
      chk("reset outs", {dout, fco, dco, frame_start, busy, s_ready}, 64'h0);
      chk("reset cnt", underrun_cnt, 64'h0);
      chk("reset cnt2", underrun_cnt2, 64'h0);

      rstn = 1'b1;
      @(negedge clk);
      chk("idle s_ready", s_ready, 64'h0);
      chk("idle busy", busy, 64'h0);

      enable = 1'b1; s_valid = 1'b1;
      s_data = {12'h123, 12'h0F0, 12'h3C9, 12'hA5C};
      @(negedge clk);
      chk("load s_ready", s_ready, 64'h1);
      chk("load frame_start", frame_start, 64'h0);
      @(negedge clk);
      frame("a5c", {12'h123, 12'h0F0, 12'h3C9, 12'hA5C}, 1'b1, -1, -1);

      s_data = {4{12'h001}};
      @(negedge clk);
      frame("b2b_001", {4{12'h001}}, 1'b1, -1, -1);
      s_data = {4{12'hFFF}};
      @(negedge clk);
      frame("b2b_fff", {4{12'hFFF}}, 1'b1, -1, -1);
      chk("no underrun", underrun_cnt, 64'h0);

      s_valid = 1'b0;
      @(negedge clk);
      frame("underrun1", {4{12'h800}}, 1'b1, -1, -1);
      chk("underrun cnt 1", underrun_cnt, 64'h1);
      chk("underrun cnt2 1", underrun_cnt2, 64'h1);
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         frame("underrun_more", {4{12'h800}}, 1'b1, -1, -1);
      end
      chk("underrun cnt 5", underrun_cnt, 64'h5);
      chk("underrun cnt2 sat", underrun_cnt2, 64'h3);

      s_valid = 1'b1; s_data = {4{12'h5A3}};
      @(negedge clk);
      frame("5a3", {4{12'h5A3}}, 1'b1, -1, -1);
      test_mode = 1'b1;
      @(negedge clk);
      frame("tm_pending", {4{12'h5A3}}, 1'b0, -1, -1);
      for (int j = 0; j < 4097; j++) begin
         rj = 12'(j);
         @(negedge clk);
         frame("ramp", {4{rj}}, 1'b0, -1, -1);
      end
      test_mode = 1'b0;
      @(negedge clk);
      frame("ramp_tail", {4{12'h001}}, 1'b1, -1, -1);
      chk("tm no underrun", underrun_cnt, 64'h5);

      s_data = {4{12'hC3A}};
      @(negedge clk);
      frame("enable_drop", {4{12'hC3A}}, 1'b0, 3, -1);
      @(negedge clk);
      chk("after drop outs", {dout, fco, dco, frame_start, busy, s_ready}, 64'h0);
      @(negedge clk);
      chk("still idle", busy, 64'h0);

      s_data = {4{12'h9E7}}; enable = 1'b1;
      @(negedge clk);
      chk("reload s_ready", s_ready, 64'h1);
      @(negedge clk);
      frame("reset_mid", {4{12'h9E7}}, 1'b0, -1, 5);
      enable = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("post reset outs", {dout, fco, dco, frame_start, busy, s_ready}, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
